w_expand_16_64: RTL and testbench

//  SHA-256 message-schedule expander, directly downstream of the 16-word loader.

---
 rtl/w_expand_16_64.sv | 135 +++++++++++++
 tb/tb_w_expand_16_64.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/w_expand_16_64.sv
// SHA-256 message-schedule expander: loads W[0..15] and streams W[0..W_LENGTH-1] with valid/ready.
// Optional macro W_VECTOR_OUT_EN adds a w_vector output collecting every emitted word.
module w_expand_16_64 #(
    parameter int W_LENGTH = 64,
    localparam int IDX_W = $clog2(W_LENGTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             w_16_complete,
    input  logic [511:0]     w16_vector,
    input  logic             w_ready,
    output logic             w_valid,
    output logic [31:0]      w_word,
    output logic [IDX_W-1:0] w_index,
    output logic             w_last,
    output logic             busy,
`ifdef W_VECTOR_OUT_EN
    output logic [32*W_LENGTH-1:0] w_vector,
`endif
    output logic             done
);

    localparam int DATA_W = 32;
    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(W_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   win [16];
    logic [IDX_W-1:0]    t;
    logic                load;
    logic                beat;
    logic [DATA_W-1:0]   new_word;

    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next window entry, computed from the oldest word onward; carries wrap mod 2^32.
    assign new_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        beat       = 1'b0;
        w_valid    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (w_16_complete) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                w_valid = 1'b1;
                busy    = 1'b1;
                beat    = w_ready;
                if (w_ready && (t == LAST_T)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Dropping enable abandons the block outright: no load, no shift, no done pulse.
        if (!enable) begin
            state_next = IDLE;
            load       = 1'b0;
            beat       = 1'b0;
        end
    end

    assign w_word  = (state == RUN) ? win[0] : '0;
    assign w_index = (state == RUN) ? t : '0;
    assign w_last  = w_valid && (t == LAST_T);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            t <= '0;
        end else if (!enable) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            t <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) win[i] <= w16_vector[32*i +: 32];
            t <= '0;
        end else if (beat) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= new_word;
            t       <= t + 1'b1;
        end else if (state == DONE) begin
            t <= '0;
        end
    end

`ifdef W_VECTOR_OUT_EN
    // Collected words persist after the block so the consumer can read them in IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_vector <= '0;
        end else if (!enable || load) begin
            w_vector <= '0;
        end else if (beat) begin
            w_vector[32*t +: 32] <= win[0];
        end
    end
`endif

endmodule

// File: tb/tb_w_expand_16_64.sv
// Directed bench for w_expand_16_64: "abc" schedule, stalls, re-strobe, enable drop, async reset.
// Build with W_VECTOR_OUT_EN defined to also exercise the w_vector output.
module tb_w_expand_16_64;

    localparam int N = 64;
    localparam int IW = $clog2(N);

    logic          clock;
    logic          reset;
    logic          enable;
    logic          w_16_complete;
    logic [511:0]  w16_vector;
    logic          w_ready;
    logic          w_valid;
    logic [31:0]   w_word;
    logic [IW-1:0] w_index;
    logic          w_last;
    logic          busy;
    logic          done;
`ifdef W_VECTOR_OUT_EN
    logic [32*N-1:0] w_vector;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0]  model [N];
    logic [31:0]  got   [N];
    logic [511:0] abc_vec;
    logic [511:0] alt_vec;

    typedef struct {
        int          t;
        logic [31:0] word;
    } vec_t;
    vec_t tbl [6];

    w_expand_16_64 #(.W_LENGTH(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .w_16_complete (w_16_complete),
        .w16_vector    (w16_vector),
        .w_ready       (w_ready),
        .w_valid       (w_valid),
        .w_word        (w_word),
        .w_index       (w_index),
        .w_last        (w_last),
        .busy          (busy),
`ifdef W_VECTOR_OUT_EN
        .w_vector      (w_vector),
`endif
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void build_model(input logic [511:0] v);
        for (int i = 0; i < 16; i++) model[i] = v[32*i +: 32];
        for (int i = 16; i < N; i++) begin
            model[i] = (rotr(model[i-2], 17) ^ rotr(model[i-2], 19) ^ (model[i-2] >> 10))
                     + model[i-7]
                     + (rotr(model[i-15], 7) ^ rotr(model[i-15], 18) ^ (model[i-15] >> 3))
                     + model[i-16];
        end
    endfunction

    task automatic load_block(input logic [511:0] v);
        w16_vector    = v;
        w_16_complete = 1'b1;
        @(negedge clock);
        w_16_complete = 1'b0;
    endtask

    // Called at a negedge one cycle after load; mode 0 = always ready, 1 = random ready.
    // abort_kind 1 drops enable at abort_t, 2 pulls reset asynchronously at abort_t.
    task automatic stream(input int mode, input int repulse_t, input int abort_t, input int abort_kind);
        int          exp_t = 0;
        bit          stalled = 0;
        bit          fin = 0;
        bit          rdy;
        logic [31:0] pw = '0;
        logic [IW-1:0] pi = '0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            check("w_valid_run", w_valid, 1'b1);
            check("w_index", w_index, exp_t);
            check("w_word", w_word, model[exp_t]);
            check("w_last", w_last, (exp_t == N - 1));
            if (stalled) begin
                check("stall_word", w_word, pw);
                check("stall_index", w_index, pi);
            end
            got[exp_t] = w_word;
            if (abort_kind == 1 && exp_t == abort_t) begin
                enable  = 1'b0;
                w_ready = 1'b1;
                @(negedge clock);
                check("en_drop_busy", busy, 1'b0);
                check("en_drop_valid", w_valid, 1'b0);
                check("en_drop_done", done, 1'b0);
                check("en_drop_index", w_index, 0);
                @(negedge clock);
                check("en_drop_done2", done, 1'b0);
                enable = 1'b1;
                return;
            end
            if (abort_kind == 2 && exp_t == abort_t) begin
                w_ready = 1'b1;
                #2 reset = 1'b0;
                #1;
                check("rst_valid", w_valid, 1'b0);
                check("rst_word", w_word, 0);
                check("rst_index", w_index, 0);
                check("rst_last", w_last, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check("rst_release_busy", busy, 1'b0);
                return;
            end
            if (exp_t == repulse_t) begin
                w16_vector    = alt_vec;
                w_16_complete = 1'b1;
            end else begin
                w_16_complete = 1'b0;
            end
            rdy     = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            w_ready = rdy;
            stalled = !rdy;
            pw      = w_word;
            pi      = w_index;
            if (rdy) begin
                if (exp_t == N - 1) fin = 1;
                else exp_t++;
            end
            @(negedge clock);
        end
        w_16_complete = 1'b0;
        if (!fin) begin
            check("stream_timeout", 0, 1);
            return;
        end
        // DONE cycle; a strobe here must be ignored.
        check("done_pulse", done, 1'b1);
        check("done_valid", w_valid, 1'b0);
        check("done_busy", busy, 1'b1);
        w16_vector    = abc_vec;
        w_16_complete = 1'b1;
        @(negedge clock);
        w_16_complete = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_valid", w_valid, 1'b0);
    endtask

    initial begin
        abc_vec           = '0;
        abc_vec[31:0]     = 32'h61626380;
        abc_vec[511:480]  = 32'h00000018;
        alt_vec           = {16{32'hDEADBEEF}};
        tbl[0] = '{t: 0,  word: 32'h61626380};
        tbl[1] = '{t: 1,  word: 32'h00000000};
        tbl[2] = '{t: 14, word: 32'h00000000};
        tbl[3] = '{t: 15, word: 32'h00000018};
        tbl[4] = '{t: 16, word: 32'h61626380};
        tbl[5] = '{t: 17, word: 32'h000F0000};
        build_model(abc_vec);

        reset         = 1'b0;
        enable        = 1'b1;
        w_16_complete = 1'b0;
        w16_vector    = '0;
        w_ready       = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_valid", w_valid, 1'b0);
        check("reset_word", w_word, 0);
        check("reset_index", w_index, 0);
        check("reset_last", w_last, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        load_block(abc_vec);
        stream(0, -1, -1, 0);
        for (int i = 0; i < 6; i++) check($sformatf("abc_w%0d", tbl[i].t), got[tbl[i].t], tbl[i].word);
`ifdef W_VECTOR_OUT_EN
        check("vec_w0", w_vector[31:0], 32'h61626380);
        check("vec_w17", w_vector[575:544], 32'h000F0000);
        for (int i = 0; i < N; i++) check($sformatf("vec_w%0d", i), w_vector[32*i +: 32], model[i]);
`endif

        load_block(abc_vec);
`ifdef W_VECTOR_OUT_EN
        check("vec_clear_on_load", w_vector[31:0], 0);
`endif
        stream(1, -1, -1, 0);

        load_block(abc_vec);
        stream(0, 20, -1, 0);

        load_block(abc_vec);
        stream(0, -1, 30, 1);
        load_block(abc_vec);
        stream(0, -1, -1, 0);

        load_block(abc_vec);
        stream(1, -1, 40, 2);
        load_block(abc_vec);
        stream(0, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
